lcd_pixel_compositor: RTL
=========================

# lcd_pixel_compositor

Parametrised per-pixel colour compositor between the game/text generators and the 800×480 RGB LCD pins. Takes the tile type, N text-overlay hit bits and the LCD timing signals for the current pixel, resolves priority, looks the result up in a runtime-programmable palette and drives registered R/G/B together with delayed sync/DE, keeping all outputs aligned. Palette writes go to shadow registers and are committed atomically at frame start, so colour changes never tear mid-frame.

## Interface
- NUM_OVL, 2, number of text overlay channels (1..11)
- TILE_LOG2, 5, log2 of tile edge in pixels (32-px tiles)
- XW, 11, width of pixel coordinates
- COLOR_W, 8, bits per colour channel (4..8)

- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- de_in  in  1  LCD data enable for current pixel
- hsync_in, vsync_in  in  1 each  LCD syncs, passed through delayed
- x, y  in  XW each  current pixel coordinate
- frame_start  in  1  single-cycle pulse once per frame (during vertical blanking); commits palette
- tile_type  in  2  0 None, 1 Body, 2 Brick, 3 Apple
- ovl_hit  in  NUM_OVL  bit i high = overlay channel i pixel set
- pal_we  in  1  palette write strobe
- pal_addr  in  4  0-3 tile colours, 4..4+NUM_OVL-1 overlay colours, 15 grid colour
- pal_wdata  in  3*COLOR_W  {R,G,B}
- rgb  out  3*COLOR_W  {R,G,B} pixel colour
- de_out, hsync_out, vsync_out  out  1 each  delayed timing signals
- pal_dirty  out  1  shadow palette differs from active (write pending commit)

## Operation
- Two-stage pipeline. Stage 1 registers de, syncs, tile_type, ovl_hit and grid flag (x[TILE_LOG2-1:0]==0 or y[TILE_LOG2-1:0]==0). Stage 2 selects colour and registers outputs.
- Priority, highest first: de low → rgb=0; lowest-index set ovl_hit bit → overlay colour i; grid flag and tile_type==None (GRID_EN only) → grid colour; else tile colour[tile_type].
- Palette: shadow and active register sets, 4+NUM_OVL+1 entries. pal_we writes shadow[pal_addr]; addresses 4+NUM_OVL..14 ignored (no effect, pal_dirty unchanged). Colour selection reads active set only.
- frame_start copies shadow → active in one cycle. pal_we and frame_start in same cycle: the written word is included in the commit.
- pal_dirty: set the cycle after any accepted write; cleared the cycle after frame_start; simultaneous write+frame_start leaves it clear.
- Reset (8-bit values, MSBs taken when COLOR_W<8), shadow and active: tile 0 FFFFFF, 1 08FF00, 2 808080, 3 FF0000; overlay 0 FF8800, overlay 1 0808FF, overlays ≥2 FFFFFF; grid C0C0C0. rgb=0, de_out=0, hsync_out=vsync_out=0, pal_dirty=0, pipeline flops 0.
- Reset asserted mid-frame: all outputs return to reset values immediately; palette reverts to defaults.

## Timing
- Fixed latency 2 cycles from x/y/tile_type/ovl_hit/de_in/syncs to rgb/de_out/syncs; all outputs mutually aligned.
- Palette commit visible on rgb for pixels whose inputs arrive from the cycle after frame_start onward; pixels already in the pipeline use the old active colours when they are resolved in stage 2 before the commit edge.
- No back-pressure; one pixel per cycle continuously.

## Configuration
- LCD_COMP_GRID_EN defined: grid rule active, palette address 15 writable.
- Undefined: grid flag logic and grid registers removed; address 15 writes ignored; None tiles always use tile colour 0.

## Test plan
- Reset, de_in=1, tile_type=1, no overlays → 2 cycles later rgb=08FF00, de_out=1; de_in=0 → rgb=000000.
- ovl_hit=2'b11, tile_type=3 → rgb=FF8800 (channel 0 wins); ovl_hit=2'b10 → 0808FF.
- Write addr 3 = 00FF00 mid-frame → pal_dirty=1, Apple stays FF0000 until frame_start; after commit Apple=00FF00, pal_dirty=0.
- pal_we to addr 1 (0000FF) in same cycle as frame_start → Body=0000FF on next pixels, pal_dirty stays 0; write to addr 10 with NUM_OVL=2 → ignored.
- GRID_EN: x=64, tile_type=0 → C0C0C0; x=64, tile_type=1 → 08FF00; x=65, tile_type=0 → FFFFFF; without macro x=64 → FFFFFF.
- Assert rst during active line after palette commits → outputs 0 immediately; after release tile 3 → FF0000.

Source files
------------

// File: rtl/lcd_pixel_compositor.sv
// Two-stage LCD pixel compositor: priority resolve, palette lookup and aligned timing outputs.
// Optional grid overlay is enabled by defining LCD_COMP_GRID_EN.
module lcd_pixel_compositor #(
  parameter int NUM_OVL   = 2,
  parameter int TILE_LOG2 = 5,
  parameter int XW        = 11,
  parameter int COLOR_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [XW-1:0]          x,
  input  logic [XW-1:0]          y,
  input  logic                   frame_start,
  input  logic [1:0]             tile_type,
  input  logic [NUM_OVL-1:0]     ovl_hit,
  input  logic                   pal_we,
  input  logic [3:0]             pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_wdata,
  output logic [3*COLOR_W-1:0]   rgb,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   pal_dirty
);

  localparam int GRID_IDX = 4 + NUM_OVL;
`ifdef LCD_COMP_GRID_EN
  localparam int NPAL = 4 + NUM_OVL + 1;
`else
  localparam int NPAL = 4 + NUM_OVL;
`endif
  localparam int IDX_W = $clog2(NPAL);
  localparam logic [4:0] LOW_LIMIT = 5'(4 + NUM_OVL);

  // Reset colours are defined at 8 bits per channel; narrower builds keep the MSBs.
  function automatic logic [3*COLOR_W-1:0] pal_default(input int idx);
    logic [23:0] c;
    if (idx == GRID_IDX)  c = 24'hC0C0C0;
    else if (idx == 0)    c = 24'hFFFFFF;
    else if (idx == 1)    c = 24'h08FF00;
    else if (idx == 2)    c = 24'h808080;
    else if (idx == 3)    c = 24'hFF0000;
    else if (idx == 4)    c = 24'hFF8800;
    else if (idx == 5)    c = 24'h0808FF;
    else                  c = 24'hFFFFFF;
    return {c[23 -: COLOR_W], c[15 -: COLOR_W], c[7 -: COLOR_W]};
  endfunction

  logic [3*COLOR_W-1:0] shadow_q [NPAL];
  logic [3*COLOR_W-1:0] shadow_d [NPAL];
  logic [3*COLOR_W-1:0] active_q [NPAL];
  logic [3*COLOR_W-1:0] active_d [NPAL];
  logic                 dirty_q, dirty_d;
  logic                 wr_ok_s;
  logic [IDX_W-1:0]     wr_idx_s;

  logic                 de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]           tile1_q, tile1_d;
  logic [NUM_OVL-1:0]   ovl1_q, ovl1_d;
  logic                 grid1_q, grid1_d;

  logic [3*COLOR_W-1:0] rgb_q, rgb_d, ovl_col_s;
  logic                 de2_q, hs2_q, vs2_q;
  logic                 unused_xy;

  assign unused_xy = ^{x, y};

  // Decode palette write address; out-of-range addresses are dropped.
  always_comb begin
    wr_ok_s  = 1'b0;
    wr_idx_s = '0;
    if (pal_we && ({1'b0, pal_addr} < LOW_LIMIT)) begin
      wr_ok_s  = 1'b1;
      wr_idx_s = IDX_W'(pal_addr);
    end
`ifdef LCD_COMP_GRID_EN
    else if (pal_we && pal_addr == 4'd15) begin
      wr_ok_s  = 1'b1;
      wr_idx_s = IDX_W'(GRID_IDX);
    end
`endif
    else begin
      wr_ok_s  = 1'b0;
    end
  end

  // Shadow update and atomic commit; a same-cycle write rides along into the commit.
  always_comb begin
    for (int i = 0; i < NPAL; i++) begin
      shadow_d[i] = (wr_ok_s && (int'(wr_idx_s) == i)) ? pal_wdata : shadow_q[i];
      active_d[i] = frame_start ? shadow_d[i] : active_q[i];
    end
    if (frame_start) dirty_d = 1'b0;
    else if (wr_ok_s) dirty_d = 1'b1;
    else dirty_d = dirty_q;
  end

  // Palette register sets and dirty flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPAL; i++) begin
        shadow_q[i] <= pal_default(i);
        active_q[i] <= pal_default(i);
      end
      dirty_q <= 1'b0;
    end else begin
      for (int i = 0; i < NPAL; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  // Stage 1 next-state: capture timing, tile, overlays and grid flag.
  always_comb begin
    de1_d   = de_in;
    hs1_d   = hsync_in;
    vs1_d   = vsync_in;
    tile1_d = tile_type;
    ovl1_d  = ovl_hit;
`ifdef LCD_COMP_GRID_EN
    grid1_d = (x[TILE_LOG2-1:0] == '0) || (y[TILE_LOG2-1:0] == '0);
`else
    grid1_d = 1'b0;
`endif
  end

  // Lowest-index overlay wins, so scan from the top down.
  always_comb begin
    ovl_col_s = '0;
    for (int i = NUM_OVL - 1; i >= 0; i--) begin
      ovl_col_s = ovl1_q[i] ? active_q[4+i] : ovl_col_s;
    end
  end

  // Stage 2 colour priority resolve against the active palette.
  always_comb begin
    rgb_d = '0;
    if (!de1_q) rgb_d = '0;
    else if (|ovl1_q) rgb_d = ovl_col_s;
`ifdef LCD_COMP_GRID_EN
    else if (grid1_q && tile1_q == 2'd0) rgb_d = active_q[GRID_IDX];
`endif
    else rgb_d = active_q[tile1_q];
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      tile1_q <= 2'd0;
      ovl1_q  <= '0;
      grid1_q <= 1'b0;
      rgb_q   <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      tile1_q <= tile1_d;
      ovl1_q  <= ovl1_d;
      grid1_q <= grid1_d;
      rgb_q   <= rgb_d;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign rgb       = rgb_q;
  assign de_out    = de2_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign pal_dirty = dirty_q;

endmodule
